// File: rtl/ysyx_23060208_lsu_pkg.sv
// ysyx_23060208_lsu_pkg: state encoding, AXI constants and size codes
// shared by the data-side load/store unit.
package ysyx_23060208_lsu_pkg;

  typedef logic [2:0] lsu_state_t;

  localparam lsu_state_t S_IDLE    = 3'd0;
  localparam lsu_state_t S_RD_ADDR = 3'd1;
  localparam lsu_state_t S_RD_DATA = 3'd2;
  localparam lsu_state_t S_WR_REQ  = 3'd3;
  localparam lsu_state_t S_WR_RESP = 3'd4;
  localparam lsu_state_t S_RESP    = 3'd5;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

endpackage

// File: rtl/ysyx_23060208_lsu_lane.sv
// ysyx_23060208_lsu_lane: byte-lane placement and strobes for stores,
// lane extraction and sign/zero extension for loads.
module ysyx_23060208_lsu_lane
  import ysyx_23060208_lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BUS_WIDTH  = 64
) (
  input  logic [$clog2(BUS_WIDTH/8)-1:0] off,
  input  logic [1:0]                     size,
  input  logic                           is_unsigned,
  input  logic [DATA_WIDTH-1:0]          wdata_in,
  input  logic [BUS_WIDTH-1:0]           rdata_in,
  output logic [BUS_WIDTH-1:0]           bus_wdata,
  output logic [BUS_WIDTH/8-1:0]         bus_wstrb,
  output logic [DATA_WIDTH-1:0]          rdata_out
);

  logic [BUS_WIDTH-1:0]   wide;
  logic [BUS_WIDTH/8-1:0] strb_base;
  logic [BUS_WIDTH-1:0]   rd_shift;
  logic [DATA_WIDTH-1:0]  raw;
  logic                   sign;
  logic                   fill;
  int                     nbytes;
  int                     nbits;
  logic                   unused_hi;

  always_comb begin
    wide = '0;
    wide[DATA_WIDTH-1:0] = wdata_in;
    bus_wdata = wide << {off, 3'b000};
  end

  always_comb begin
    nbytes = 1 << size;
    strb_base = '0;
    for (int i = 0; i < BUS_WIDTH/8; i++)
      strb_base[i] = (i < nbytes);
    bus_wstrb = strb_base << off;
  end

  // Shift the addressed lane down to bit 0, then extend above 2^size bytes.
  always_comb begin
    rd_shift = rdata_in >> {off, 3'b000};
    raw = rd_shift[DATA_WIDTH-1:0];
    sign = 1'b0;
    unique case (size)
      SIZE_B:  sign = raw[7];
      SIZE_H:  sign = raw[15];
      SIZE_W:  sign = raw[31];
      default: sign = raw[DATA_WIDTH-1];
    endcase
    fill = sign & ~is_unsigned;
    nbits = 8 << size;
    for (int i = 0; i < DATA_WIDTH; i++)
      rdata_out[i] = (i < nbits) ? raw[i] : fill;
  end

  assign unused_hi = ^rd_shift;

endmodule

// File: rtl/ysyx_23060208_lsu.sv
// ysyx_23060208_lsu: single-outstanding load/store unit on AXI4.
// Define YSYX_23060208_LSU_MISALIGN_CHK_EN to fault misaligned requests.
module ysyx_23060208_lsu
  import ysyx_23060208_lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BUS_WIDTH  = 64,
  parameter int ID_WIDTH   = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [1:0]             req_size,
  input  logic                   req_unsigned,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [DATA_WIDTH-1:0]  req_wdata,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [DATA_WIDTH-1:0]  resp_rdata,
  output logic                   resp_err,
  output logic                   awvalid,
  input  logic                   awready,
  output logic [ADDR_WIDTH-1:0]  awaddr,
  output logic [ID_WIDTH-1:0]    awid,
  output logic [7:0]             awlen,
  output logic [2:0]             awsize,
  output logic [1:0]             awburst,
  output logic                   wvalid,
  input  logic                   wready,
  output logic [BUS_WIDTH-1:0]   wdata,
  output logic [BUS_WIDTH/8-1:0] wstrb,
  output logic                   wlast,
  input  logic                   bvalid,
  output logic                   bready,
  input  logic [1:0]             bresp,
  input  logic [ID_WIDTH-1:0]    bid,
  output logic                   arvalid,
  input  logic                   arready,
  output logic [ADDR_WIDTH-1:0]  araddr,
  output logic [ID_WIDTH-1:0]    arid,
  output logic [7:0]             arlen,
  output logic [2:0]             arsize,
  output logic [1:0]             arburst,
  input  logic                   rvalid,
  output logic                   rready,
  input  logic [BUS_WIDTH-1:0]   rdata,
  input  logic [1:0]             rresp,
  input  logic                   rlast,
  input  logic [ID_WIDTH-1:0]    rid
);

  localparam int OFF_W = $clog2(BUS_WIDTH/8);

  lsu_state_t            state;
  logic [ID_WIDTH-1:0]   id_cnt;
  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  arvalid_q;
  logic                  awvalid_q;
  logic                  wvalid_q;
  logic [DATA_WIDTH-1:0] ld_data;
  logic [2:0]            lo_mask;
  logic [ADDR_WIDTH-1:0] addr_al;
  logic                  aw_done;
  logic                  w_done;
  logic                  unused_ok;
`ifdef YSYX_23060208_LSU_MISALIGN_CHK_EN
  logic                  misal;
`endif

  always_comb begin
    lo_mask = 3'b000;
    unique case (req_size)
      SIZE_B:  lo_mask = 3'b000;
      SIZE_H:  lo_mask = 3'b001;
      SIZE_W:  lo_mask = 3'b011;
      default: lo_mask = 3'b111;
    endcase
  end

  // Clearing the low bits is a no-op for aligned requests.
  assign addr_al = {req_addr[ADDR_WIDTH-1:3], req_addr[2:0] & ~lo_mask};
`ifdef YSYX_23060208_LSU_MISALIGN_CHK_EN
  assign misal = |(req_addr[2:0] & lo_mask);
`endif

  assign aw_done = ~awvalid_q | awready;
  assign w_done  = ~wvalid_q | wready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      id_cnt     <= '0;
      id_q       <= '0;
      addr_q     <= '0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      wdata_q    <= '0;
      arvalid_q  <= 1'b0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: if (req_valid) begin
          addr_q  <= addr_al;
          size_q  <= req_size;
          uns_q   <= req_unsigned;
          wdata_q <= req_wdata;
          id_q    <= id_cnt;
          id_cnt  <= id_cnt + 1'b1;
`ifdef YSYX_23060208_LSU_MISALIGN_CHK_EN
          if (misal) begin
            resp_rdata <= '0;
            resp_err   <= 1'b1;
            state      <= S_RESP;
          end else
`endif
          if (req_we) begin
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            state     <= S_WR_REQ;
          end else begin
            arvalid_q <= 1'b1;
            state     <= S_RD_ADDR;
          end
        end
        S_RD_ADDR: if (arready) begin
          arvalid_q <= 1'b0;
          state     <= S_RD_DATA;
        end
        S_RD_DATA: if (rvalid && rid == id_q) begin
          resp_rdata <= ld_data;
          resp_err   <= rresp[1];
          state      <= S_RESP;
        end
        S_WR_REQ: begin
          if (awready) awvalid_q <= 1'b0;
          if (wready)  wvalid_q  <= 1'b0;
          if (aw_done && w_done) state <= S_WR_RESP;
        end
        S_WR_RESP: if (bvalid && bid == id_q) begin
          resp_rdata <= '0;
          resp_err   <= bresp[1];
          state      <= S_RESP;
        end
        S_RESP: if (resp_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  ysyx_23060208_lsu_lane #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUS_WIDTH  (BUS_WIDTH)
  ) u_lane (
    .off         (addr_q[OFF_W-1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .wdata_in    (wdata_q),
    .rdata_in    (rdata),
    .bus_wdata   (wdata),
    .bus_wstrb   (wstrb),
    .rdata_out   (ld_data)
  );

  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);
  assign rready     = (state == S_RD_DATA);
  assign bready     = (state == S_WR_RESP);

  assign arvalid = arvalid_q;
  assign araddr  = addr_q;
  assign arid    = id_q;
  assign arlen   = 8'd0;
  assign arsize  = {1'b0, size_q};
  assign arburst = BURST_INCR;

  assign awvalid = awvalid_q;
  assign awaddr  = addr_q;
  assign awid    = id_q;
  assign awlen   = 8'd0;
  assign awsize  = {1'b0, size_q};
  assign awburst = BURST_INCR;

  assign wvalid = wvalid_q;
  assign wlast  = 1'b1;

  assign unused_ok = ^{rlast, rresp[0], bresp[0]};

endmodule
